mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle CPU's data/instruction port.
- Answers read and write requests from the CPU's memory-access FSM over a request/acknowledge handshake.
- Inserts a programmable number of wait states per access, so CPU stall handling can be exercised against a non-ideal memory.
- Holds a word-addressed storage array and flags misaligned or out-of-range accesses.

---
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states and a req/ack handshake.
// Misaligned or out-of-range accesses are acknowledged after one edge with o_err set.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_busy,
    output logic [1:0]  o_state
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  idx_q;
    logic [31:0]            wdata_q;
    logic [31:0]            mem [DEPTH];

    logic                   addr_err_c;
    logic                   go_ack_c;
    logic                   acc_we_c;
    logic                   acc_err_c;
    logic [ADDR_WIDTH-1:0]  acc_idx_c;
    logic [31:0]            acc_wdata_c;

    assign addr_err_c = (i_addr[1:0] != 2'b00) || ((i_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign o_state    = state;

    // Access performed on the edge entering ACK: live inputs from IDLE, latched ones from WAIT.
    always_comb begin
        acc_we_c    = we_q;
        acc_idx_c   = idx_q;
        acc_wdata_c = wdata_q;
        acc_err_c   = 1'b0;
        go_ack_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                acc_we_c    = i_we;
                acc_idx_c   = i_addr[ADDR_WIDTH+1:2];
                acc_wdata_c = i_wdata;
                acc_err_c   = addr_err_c;
                go_ack_c    = i_req && (addr_err_c || (WAIT_CYCLES == 0));
            end
            ST_WAIT: go_ack_c = (cnt == '0);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            o_rdata <= '0;
            o_ack   <= 1'b0;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            o_ack <= 1'b0;
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        we_q    <= i_we;
                        idx_q   <= i_addr[ADDR_WIDTH+1:2];
                        wdata_q <= i_wdata;
                        o_busy  <= 1'b1;
                        if (go_ack_c) begin
                            state <= ST_ACK;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (go_ack_c) begin
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            if (go_ack_c) begin
                o_ack <= 1'b1;
                o_err <= acc_err_c;
                if (!acc_err_c) begin
                    if (acc_we_c) begin
                        mem[acc_idx_c] <= acc_wdata_c;
                    end else begin
                        o_rdata <= mem[acc_idx_c];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) checked every cycle against
// a transaction-level model, plus directed scenarios with hand-computed expectations.
module tb_mem_responder;

    logic        clk;
    logic        rst_n [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];
    logic [1:0]  state [2];

    int n_total = 0;
    int n_pass  = 0;

    mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut_w2 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_req(req[0]), .i_we(we[0]),
        .i_addr(addr[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]), .o_ack(ack[0]),
        .o_err(err[0]), .o_busy(busy[0]), .o_state(state[0])
    );

    mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut_w0 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_req(req[1]), .i_we(we[1]),
        .i_addr(addr[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]), .o_ack(ack[1]),
        .o_err(err[1]), .o_busy(busy[1]), .o_state(state[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Transaction-level model: each accepted request completes a fixed number of edges later.
    logic [31:0] m_mem   [2][256];
    logic [31:0] m_rdata [2];
    logic        m_pend  [2];
    logic        m_ack   [2];
    logic        m_err   [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    int          m_rem   [2];

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic void m_complete(input int k);
        int idx;
        idx = int'(m_addr[k] / 4) % 256;
        m_pend[k] = 1'b0;
        m_ack[k]  = 1'b1;
        if (!m_err[k]) begin
            if (m_we[k]) m_mem[k][idx] = m_wdata[k];
            else         m_rdata[k] = m_mem[k][idx];
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                for (int i = 0; i < 256; i++) m_mem[k][i] = 32'd0;
                m_rdata[k] = 32'd0;
                m_pend[k]  = 1'b0;
                m_ack[k]   = 1'b0;
                m_err[k]   = 1'b0;
                m_rem[k]   = 0;
            end else if (m_ack[k]) begin
                m_ack[k] = 1'b0;
            end else if (m_pend[k]) begin
                m_rem[k] = m_rem[k] - 1;
                if (m_rem[k] == 0) m_complete(k);
            end else if (req[k]) begin
                m_we[k]    = we[k];
                m_addr[k]  = addr[k];
                m_wdata[k] = wdata[k];
                m_err[k]   = (addr[k] % 4 != 0) || (addr[k] >= 32'd1024);
                m_rem[k]   = m_err[k] ? 0 : wait_of(k);
                if (m_rem[k] == 0) m_complete(k);
                else               m_pend[k] = 1'b1;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_ack[%0d]", k),   32'(ack[k]),   32'(m_ack[k]));
            chk($sformatf("model_err[%0d]", k),   32'(err[k]),   32'(m_ack[k] && m_err[k]));
            chk($sformatf("model_busy[%0d]", k),  32'(busy[k]),  32'(m_pend[k] || m_ack[k]));
            chk($sformatf("model_state[%0d]", k), 32'(state[k]),
                m_ack[k] ? 32'd2 : (m_pend[k] ? 32'd1 : 32'd0));
            chk($sformatf("model_rdata[%0d]", k), rdata[k], m_rdata[k]);
        end
    end

    // Issues one request on instance k; reports edges from sampling edge to ack (0 = timeout).
    task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e);
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        lat = 0;
        e   = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            req[k] = 1'b0;
            if (ack[k]) begin
                lat = n;
                e   = err[k];
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          acks;
        int          busy_cnt;
        logic        e;
        logic [31:0] last_wd;
        logic [31:0] ra;
        int          sel;

        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0;
            addr[k] = 32'd0; wdata[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata[0], 32'd0);
        chk("reset_busy",  32'(busy[0]), 32'd0);
        chk("reset_state", 32'(state[0]), 32'd0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Read 0x10: ack 3 edges after sampling, busy for 3 cycles.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        busy_cnt = 0;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            req[0] = 1'b0;
            if (busy[0]) busy_cnt++;
            if (ack[0] && lat == 0) lat = n;
        end
        chk("rd10_latency", 32'(lat), 32'd3);
        chk("rd10_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("rd10_rdata", rdata[0], 32'd0);

        access(0, 1'b1, 32'h40, 32'hDEAD_BEEF, lat, e);
        chk("wr40_latency", 32'(lat), 32'd3);
        chk("wr40_rdata_held", rdata[0], 32'd0);
        access(0, 1'b0, 32'h40, 32'd0, lat, e);
        chk("rd40_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("rd40_err", 32'(e), 32'd0);

        access(0, 1'b0, 32'h42, 32'd0, lat, e);
        chk("misalign_latency", 32'(lat), 32'd1);
        chk("misalign_err", 32'(e), 32'd1);
        access(0, 1'b0, 32'h400, 32'd0, lat, e);
        chk("range_latency", 32'(lat), 32'd1);
        chk("range_err", 32'(e), 32'd1);
        chk("range_rdata_held", rdata[0], 32'hDEAD_BEEF);
        access(0, 1'b0, 32'h40, 32'd0, lat, e);
        chk("rd40_again", rdata[0], 32'hDEAD_BEEF);

        // Inputs changed and req pulsed during WAIT and ACK must be ignored.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h44; wdata[0] = 32'h1111_1111;
        acks = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (ack[0]) acks++;
            if (n <= 3) begin
                req[0] = 1'b1; addr[0] = 32'h48; wdata[0] = 32'h2222_2222;
            end else begin
                req[0] = 1'b0;
            end
        end
        chk("ignore_ack_count", 32'(acks), 32'd1);
        access(0, 1'b0, 32'h44, 32'd0, lat, e);
        chk("ignore_rd44", rdata[0], 32'h1111_1111);
        access(0, 1'b0, 32'h48, 32'd0, lat, e);
        chk("ignore_rd48", rdata[0], 32'd0);

        // Reset during WAIT of a write aborts it and clears storage.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 32'h1234_5678;
        @(negedge clk);
        req[0] = 1'b0; rst_n[0] = 1'b0;
        @(negedge clk);
        chk("abort_ack", 32'(ack[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_err", 32'(err[0]), 32'd0);
        chk("abort_rdata", rdata[0], 32'd0);
        chk("abort_state", 32'(state[0]), 32'd0);
        rst_n[0] = 1'b1;
        access(0, 1'b0, 32'h80, 32'd0, lat, e);
        chk("abort_rd80", rdata[0], 32'd0);
        chk("abort_rd80_latency", 32'(lat), 32'd3);
        access(0, 1'b0, 32'h40, 32'd0, lat, e);
        chk("abort_rd40_cleared", rdata[0], 32'd0);

        // Zero wait states, req held high, alternating write/read to 0x4.
        @(negedge clk);
        last_wd = 32'hA5A5_0000;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h4; wdata[1] = last_wd;
        @(negedge clk);
        chk("w0_first_ack", 32'(ack[1]), 32'd1);
        for (int i = 1; i < 12; i++) begin
            we[1] = (i % 2 == 0);
            if (we[1]) begin
                last_wd = $urandom;
                wdata[1] = last_wd;
            end
            @(negedge clk);
            chk("w0_gap", 32'(ack[1]), 32'd0);
            @(negedge clk);
            chk("w0_ack", 32'(ack[1]), 32'd1);
            if (!we[1]) chk("w0_readback", rdata[1], last_wd);
        end
        req[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rst_n[k] = ($urandom_range(0, 299) != 0);
                req[k]   = ($urandom_range(0, 2) != 0);
                we[k]    = $urandom_range(0, 1) == 1;
                wdata[k] = $urandom;
                sel = $urandom_range(0, 9);
                ra = 32'($urandom_range(0, 15)) * 32'd4;
                if (sel == 0)      ra = ra | 32'($urandom_range(1, 3));
                else if (sel == 1) ra = ra | 32'h400;
                else if (sel == 2) ra = ra | 32'h8000_0000;
                else if (sel == 3) ra = 32'($urandom_range(0, 255)) * 32'd4;
                addr[k] = ra;
            end
        end
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b1;
            req[k]   = 1'b0;
        end
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
